alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 73 +++++++
 rtl/alu_sequencer_decode.sv | 40 ++++
 rtl/alu_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer and the datapath benches that
// drive it: state encoding, opcode values, instruction field positions and
// the opcode class encoding.
// Optional feature macro: ALU_SEQUENCER_MULDIV_EN (multiply/divide opcodes
// become legal and get a second write-back cycle for the HI half).
package alu_sequencer_pkg;

  // Control step of the sequencer; T6 is only reachable with the
  // multiply/divide feature enabled.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_e;

  // Execution class of a decoded opcode.
  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_UNARY   = 3'd1,
    CLS_MULDIV  = 3'd2,
    CLS_NOP     = 3'd3,
    CLS_HALT    = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_e;

  // Instruction word field positions.
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  // Opcode values and the contiguous two-operand range.
  localparam logic [4:0] OP_RTYPE_LO = 5'b00011;
  localparam logic [4:0] OP_RTYPE_HI = 5'b01011;
  localparam logic [4:0] OP_MUL      = 5'b01111;
  localparam logic [4:0] OP_DIV      = 5'b10000;
  localparam logic [4:0] OP_NEG      = 5'b10001;
  localparam logic [4:0] OP_NOT      = 5'b10010;
  localparam logic [4:0] OP_NOP      = 5'b11010;
  localparam logic [4:0] OP_HALT     = 5'b11011;

  // Map an opcode onto its execution class. Multiply/divide only count as
  // legal when the feature is built in; otherwise they fall to ILLEGAL.
  function automatic op_class_e classify(input logic [4:0] op);
    op_class_e cls;
    cls = CLS_ILLEGAL;
    if (op >= OP_RTYPE_LO && op <= OP_RTYPE_HI) begin
      cls = CLS_RTYPE;
    end else if (op == OP_NEG || op == OP_NOT) begin
      cls = CLS_UNARY;
`ifdef ALU_SEQUENCER_MULDIV_EN
    end else if (op == OP_MUL || op == OP_DIV) begin
      cls = CLS_MULDIV;
`endif
    end else if (op == OP_NOP) begin
      cls = CLS_NOP;
    end else if (op == OP_HALT) begin
      cls = CLS_HALT;
    end
    return cls;
  endfunction

endpackage

// File: rtl/alu_sequencer_decode.sv
// Combinational instruction decode: splits the instruction register into the
// opcode, its execution class and one-hot register selects for Ra, Rb, Rc and
// Ra+1 (HI destination of multiply/divide, wrapping from R15 to R0).
// Optional feature macro: ALU_SEQUENCER_MULDIV_EN (affects classification).
module alu_seq_decode
  import alu_sequencer_pkg::*;
(
  input  logic [31:0] ir_data,
  output logic [4:0]  op,
  output logic [2:0]  op_class,
  output logic [15:0] ra_sel,
  output logic [15:0] rb_sel,
  output logic [15:0] rc_sel,
  output logic [15:0] ra_next_sel
);

  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic [3:0] ra_next;
  logic       unused_low_bits;

  // Field extraction, class lookup and one-hot expansion of the register numbers.
  always_comb begin
    op          = ir_data[OP_MSB:OP_LSB];
    ra          = ir_data[RA_MSB:RA_LSB];
    rb          = ir_data[RB_MSB:RB_LSB];
    rc          = ir_data[RC_MSB:RC_LSB];
    ra_next     = ra + 4'd1;
    op_class    = classify(op);
    ra_sel      = 16'h0001 << ra;
    rb_sel      = 16'h0001 << rb;
    rc_sel      = 16'h0001 << rc;
    ra_next_sel = 16'h0001 << ra_next;
  end

  // The low instruction bits (immediate/unused) play no part in sequencing.
  assign unused_low_bits = ^ir_data[RC_LSB-1:0];

endmodule

// File: rtl/alu_sequencer.sv
// Control sequencer for a bus-based CPU datapath. Fetches an instruction
// (T0..T2, with T1 stalling on memory), then executes it in T3..T5 (T6 for
// the HI half of multiply/divide), producing Moore-decoded datapath strobes.
// Reset: clr, synchronous, active-low.
// Optional feature macro: ALU_SEQUENCER_MULDIV_EN -- when defined, opcodes
// 01111/10000 execute and write LO to Ra and HI to Ra+1; when undefined they
// are illegal and Zhigh_out is held at 0.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] IR_Data,
  output logic        PC_out,
  output logic        PC_in,
  output logic        IncPC,
  output logic        MAR_in,
  output logic        MDR_in,
  output logic        MDR_out,
  output logic        Read,
  output logic        IR_in,
  output logic        Y_in,
  output logic        Z_in,
  output logic        Zlow_out,
  output logic        Zhigh_out,
  output logic [15:0] R_in,
  output logic [15:0] R_out,
  output logic [4:0]  alu_instruction,
  output logic        busy,
  output logic        halted,
  output logic        illegal
);

  state_e      state;
  state_e      state_next;
  state_e      boundary_next;
  logic        illegal_q;
  logic        illegal_next;

  logic [4:0]  op;
  logic [2:0]  op_class;
  logic [15:0] ra_sel;
  logic [15:0] rb_sel;
  logic [15:0] rc_sel;
  logic [15:0] ra_next_sel;

  alu_seq_decode u_decode (
    .ir_data     (IR_Data),
    .op          (op),
    .op_class    (op_class),
    .ra_sel      (ra_sel),
    .rb_sel      (rb_sel),
    .rc_sel      (rc_sel),
    .ra_next_sel (ra_next_sel)
  );

`ifndef ALU_SEQUENCER_MULDIV_EN
  logic unused_ra_next;
  assign unused_ra_next = ^ra_next_sel;
`endif

  // State and sticky illegal flag; clr low at an edge wins from every state,
  // including a T1 memory stall and HALT.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state     <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_next;
      illegal_q <= illegal_next;
    end
  end

  // Next-state logic. run is only consulted in IDLE and at instruction
  // boundaries, so dropping it mid-instruction lets the instruction finish.
  always_comb begin
    state_next    = state;
    illegal_next  = illegal_q;
    boundary_next = run ? S_T0 : S_IDLE;
    case (state)
      S_IDLE: begin
        if (run) begin
          state_next = S_T0;
        end
      end
      S_T0: state_next = S_T1;
      S_T1: begin
        if (mem_ready) begin
          state_next = S_T2;
        end
      end
      S_T2: begin
        case (op_class)
          CLS_RTYPE, CLS_MULDIV: state_next = S_T3;
          CLS_UNARY:             state_next = S_T4;
          CLS_NOP:               state_next = boundary_next;
          CLS_HALT:              state_next = S_HALT;
          default: begin
            state_next   = S_HALT;
            illegal_next = 1'b1;
          end
        endcase
      end
      S_T3: state_next = S_T4;
      S_T4: state_next = S_T5;
      S_T5: begin
`ifdef ALU_SEQUENCER_MULDIV_EN
        if (op_class == CLS_MULDIV) begin
          state_next = S_T6;
        end else begin
          state_next = boundary_next;
        end
`else
        state_next = boundary_next;
`endif
      end
`ifdef ALU_SEQUENCER_MULDIV_EN
      S_T6: state_next = boundary_next;
`endif
      S_HALT: state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  // Moore output decode of the current step and the instruction register;
  // every strobe defaults low so IDLE and HALT drive nothing onto the bus.
  always_comb begin
    PC_out          = 1'b0;
    PC_in           = 1'b0;
    IncPC           = 1'b0;
    MAR_in          = 1'b0;
    MDR_in          = 1'b0;
    MDR_out         = 1'b0;
    Read            = 1'b0;
    IR_in           = 1'b0;
    Y_in            = 1'b0;
    Z_in            = 1'b0;
    Zlow_out        = 1'b0;
    Zhigh_out       = 1'b0;
    R_in            = 16'h0000;
    R_out           = 16'h0000;
    alu_instruction = 5'b00000;
    busy            = 1'b0;
    halted          = 1'b0;
    case (state)
      S_T0: begin
        PC_out = 1'b1;
        MAR_in = 1'b1;
        IncPC  = 1'b1;
        Z_in   = 1'b1;
        busy   = 1'b1;
      end
      S_T1: begin
        Zlow_out = 1'b1;
        PC_in    = 1'b1;
        Read     = 1'b1;
        MDR_in   = 1'b1;
        busy     = 1'b1;
      end
      S_T2: begin
        MDR_out = 1'b1;
        IR_in   = 1'b1;
        busy    = 1'b1;
      end
      S_T3: begin
        R_out = rb_sel;
        Y_in  = 1'b1;
        busy  = 1'b1;
      end
      S_T4: begin
        Z_in            = 1'b1;
        alu_instruction = op;
        R_out           = (op_class == CLS_UNARY) ? rb_sel : rc_sel;
        busy            = 1'b1;
      end
      S_T5: begin
        Zlow_out = 1'b1;
        R_in     = ra_sel;
        busy     = 1'b1;
      end
`ifdef ALU_SEQUENCER_MULDIV_EN
      S_T6: begin
        Zhigh_out = 1'b1;
        R_in      = ra_next_sel;
        busy      = 1'b1;
      end
`endif
      S_HALT: halted = 1'b1;
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: each stimulus step pushes the outputs
// expected after the next rising edge; a monitor pops and compares them on
// every falling edge. A small register-file/ALU model follows the strobes so
// the rotate example can be checked end to end.
// Optional feature macro: ALU_SEQUENCER_MULDIV_EN (selects MULDIV expectations).
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        run;
  logic        mem_ready;
  logic [31:0] IR_Data;
  logic        PC_out, PC_in, IncPC, MAR_in, MDR_in, MDR_out, Read, IR_in;
  logic        Y_in, Z_in, Zlow_out, Zhigh_out;
  logic [15:0] R_in, R_out;
  logic [4:0]  alu_instruction;
  logic        busy, halted, illegal;

  typedef struct packed {
    logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, rd, ir_in;
    logic y_in, z_in, zlow_out, zhigh_out;
    logic [15:0] r_in;
    logic [15:0] r_out;
    logic [4:0]  alu;
    logic busy, halted, illegal;
  } obs_t;

  localparam logic [31:0] IR_ROR  = 32'h53320000;
  localparam logic [31:0] IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_ILL  = 32'hF8000000;
  localparam logic [31:0] IR_HLT  = 32'hD8000000;
  localparam logic [31:0] IR_NOT  = 32'h90900000;
  localparam logic [31:0] IR_MUL  = 32'h791A0000;
  localparam logic [31:0] IR_ADD  = 32'h18000000;
  localparam logic [31:0] IR_OPB  = 32'h58000000;
  localparam logic [31:0] IR_OP2  = 32'h10000000;
  localparam logic [31:0] IR_OPC  = 32'h60000000;

  obs_t  exp_q[$];
  string name_q[$];
  obs_t  actual;
  obs_t  mon_exp;
  string mon_name;
  int    tests_run = 0;
  int    tests_failed = 0;

  logic [31:0] regs [16];
  logic [31:0] y_reg;
  logic [63:0] z_reg;
  logic [31:0] bus;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready), .IR_Data(IR_Data),
    .PC_out(PC_out), .PC_in(PC_in), .IncPC(IncPC), .MAR_in(MAR_in),
    .MDR_in(MDR_in), .MDR_out(MDR_out), .Read(Read), .IR_in(IR_in),
    .Y_in(Y_in), .Z_in(Z_in), .Zlow_out(Zlow_out), .Zhigh_out(Zhigh_out),
    .R_in(R_in), .R_out(R_out), .alu_instruction(alu_instruction),
    .busy(busy), .halted(halted), .illegal(illegal)
  );

  always_comb begin
    actual = {PC_out, PC_in, IncPC, MAR_in, MDR_in, MDR_out, Read, IR_in,
              Y_in, Z_in, Zlow_out, Zhigh_out, R_in, R_out, alu_instruction,
              busy, halted, illegal};
  end

  // Expected observation per step, written out from the step descriptions.
  function automatic obs_t expIdle();
    obs_t e = '0;
    return e;
  endfunction
  function automatic obs_t expT0();
    obs_t e = '0;
    e.pc_out = 1'b1; e.mar_in = 1'b1; e.inc_pc = 1'b1; e.z_in = 1'b1; e.busy = 1'b1;
    return e;
  endfunction
  function automatic obs_t expT1();
    obs_t e = '0;
    e.zlow_out = 1'b1; e.pc_in = 1'b1; e.rd = 1'b1; e.mdr_in = 1'b1; e.busy = 1'b1;
    return e;
  endfunction
  function automatic obs_t expT2();
    obs_t e = '0;
    e.mdr_out = 1'b1; e.ir_in = 1'b1; e.busy = 1'b1;
    return e;
  endfunction
  function automatic obs_t expT3(input logic [15:0] rb);
    obs_t e = '0;
    e.r_out = rb; e.y_in = 1'b1; e.busy = 1'b1;
    return e;
  endfunction
  function automatic obs_t expT4(input logic [15:0] rsel, input logic [4:0] op);
    obs_t e = '0;
    e.r_out = rsel; e.z_in = 1'b1; e.alu = op; e.busy = 1'b1;
    return e;
  endfunction
  function automatic obs_t expT5(input logic [15:0] ra);
    obs_t e = '0;
    e.zlow_out = 1'b1; e.r_in = ra; e.busy = 1'b1;
    return e;
  endfunction
  function automatic obs_t expT6(input logic [15:0] ra1);
    obs_t e = '0;
    e.zhigh_out = 1'b1; e.r_in = ra1; e.busy = 1'b1;
    return e;
  endfunction
  function automatic obs_t expHalt(input logic ill);
    obs_t e = '0;
    e.halted = 1'b1; e.illegal = ill;
    return e;
  endfunction

  // Datapath model: rotate-right for op 01010, add for everything else.
  function automatic logic [63:0] aluModel(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] dbl;
    if (op == 5'b01010) begin
      dbl = {a, a} >> b[4:0];
      return {32'h0, dbl[31:0]};
    end
    return {32'h0, a + b};
  endfunction

  always_comb begin
    bus = 32'h0;
    for (int i = 0; i < 16; i++) begin
      if (R_out[i]) bus = regs[i];
    end
    if (Zlow_out) bus = z_reg[31:0];
    if (Zhigh_out) bus = z_reg[63:32];
  end

  always @(posedge clk) begin
    if (!clr) begin
      regs[6] <= 32'h8000FA92;
      regs[4] <= 32'h00000008;
    end else begin
      if (Y_in) y_reg <= bus;
      if (Z_in) z_reg <= aluModel(alu_instruction, y_reg, bus);
      for (int k = 0; k < 16; k++) begin
        if (R_in[k]) regs[k] <= bus;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Drive one cycle of inputs just after a falling edge and queue what the
  // outputs must show after the following rising edge.
  task automatic applyStimulus(input logic c, input logic r, input logic m,
                               input logic [31:0] ir, input obs_t e, input string name);
    @(negedge clk);
    #1;
    clr       = c;
    run       = r;
    mem_ready = m;
    IR_Data   = ir;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic fetch(input logic [31:0] ir, input string tag);
    applyStimulus(1'b1, 1'b1, 1'b1, ir, expT0(), {tag, "_t0"});
    applyStimulus(1'b1, 1'b1, 1'b1, ir, expT1(), {tag, "_t1"});
    applyStimulus(1'b1, 1'b1, 1'b1, ir, expT2(), {tag, "_t2"});
  endtask

  // Monitor: every falling edge with a pending expectation is one comparison.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      checkOutput(mon_name, 64'(actual), 64'(mon_exp));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clr = 1'b0; run = 1'b0; mem_ready = 1'b0; IR_Data = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, expIdle(), "reset_a");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, expIdle(), "reset_b");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, expIdle(), "idle_hold");

    // Rotate example; run drops during T4 and the instruction still completes.
    fetch(IR_ROR, "ror");
    applyStimulus(1'b1, 1'b1, 1'b1, IR_ROR, expT3(16'h0040), "ror_t3");
    applyStimulus(1'b1, 1'b1, 1'b1, IR_ROR, expT4(16'h0010, 5'b01010), "ror_t4");
    applyStimulus(1'b1, 1'b0, 1'b1, IR_ROR, expT5(16'h0040), "ror_t5");
    applyStimulus(1'b1, 1'b0, 1'b1, IR_ROR, expIdle(), "ror_boundary_idle");
    applyStimulus(1'b1, 1'b0, 1'b1, IR_ROR, expIdle(), "ror_idle_hold");
    checkOutput("ror_r6_result", 64'(regs[6]), 64'h928000FA);

    // Memory stall: T1 held four cycles, then a NOP ends at the boundary.
    applyStimulus(1'b1, 1'b1, 1'b0, IR_NOP, expT0(), "stall_t0");
    applyStimulus(1'b1, 1'b1, 1'b0, IR_NOP, expT1(), "stall_t1_c1");
    applyStimulus(1'b1, 1'b1, 1'b0, IR_NOP, expT1(), "stall_t1_c2");
    applyStimulus(1'b1, 1'b1, 1'b0, IR_NOP, expT1(), "stall_t1_c3");
    applyStimulus(1'b1, 1'b1, 1'b0, IR_NOP, expT1(), "stall_t1_c4");
    applyStimulus(1'b1, 1'b1, 1'b1, IR_NOP, expT2(), "stall_t2");
    applyStimulus(1'b1, 1'b0, 1'b1, IR_NOP, expIdle(), "nop_boundary_idle");

    // Reset in T3, restart, then reset in a T1 stall.
    fetch(IR_ROR, "rst");
    applyStimulus(1'b1, 1'b1, 1'b1, IR_ROR, expT3(16'h0040), "rst_t3");
    applyStimulus(1'b0, 1'b1, 1'b1, IR_ROR, expIdle(), "reset_in_t3");
    applyStimulus(1'b1, 1'b1, 1'b1, IR_ROR, expT0(), "restart_t0");
    applyStimulus(1'b1, 1'b1, 1'b0, IR_ROR, expT1(), "restart_t1");
    applyStimulus(1'b1, 1'b1, 1'b0, IR_ROR, expT1(), "restart_t1_stall");
    applyStimulus(1'b0, 1'b1, 1'b0, IR_ROR, expIdle(), "reset_in_stall");

    // Illegal opcode 11111: HALT with illegal, run ignored until clr.
    fetch(IR_ILL, "ill");
    applyStimulus(1'b1, 1'b1, 1'b1, IR_ILL, expHalt(1'b1), "ill_halt");
    applyStimulus(1'b1, 1'b0, 1'b1, IR_ILL, expHalt(1'b1), "ill_run_low");
    applyStimulus(1'b1, 1'b1, 1'b1, IR_ILL, expHalt(1'b1), "ill_run_high");
    applyStimulus(1'b0, 1'b0, 1'b1, IR_ILL, expIdle(), "ill_cleared");

    // HALT opcode: halted without illegal.
    fetch(IR_HLT, "hlt");
    applyStimulus(1'b1, 1'b1, 1'b1, IR_HLT, expHalt(1'b0), "hlt_halt");
    applyStimulus(1'b1, 1'b1, 1'b1, IR_HLT, expHalt(1'b0), "hlt_stays");
    applyStimulus(1'b0, 1'b0, 1'b1, IR_HLT, expIdle(), "hlt_cleared");

    // Unary NOT: skips T3, boundary with run=1 starts the next fetch.
    fetch(IR_NOT, "not");
    applyStimulus(1'b1, 1'b1, 1'b1, IR_NOT, expT4(16'h0004, 5'b10010), "not_t4");
    applyStimulus(1'b1, 1'b1, 1'b1, IR_NOT, expT5(16'h0002), "not_t5");
    applyStimulus(1'b1, 1'b1, 1'b1, IR_NOT, expT0(), "not_boundary_t0");
    applyStimulus(1'b1, 1'b0, 1'b1, IR_NOT, expT1(), "not2_t1");
    applyStimulus(1'b1, 1'b0, 1'b1, IR_NOT, expT2(), "not2_t2");
    applyStimulus(1'b1, 1'b0, 1'b1, IR_NOT, expT4(16'h0004, 5'b10010), "not2_t4");
    applyStimulus(1'b1, 1'b0, 1'b1, IR_NOT, expT5(16'h0002), "not2_t5");
    applyStimulus(1'b1, 1'b0, 1'b1, IR_NOT, expIdle(), "not2_idle");

    // Edges of the two-operand opcode range.
    fetch(IR_ADD, "op03");
    applyStimulus(1'b1, 1'b1, 1'b1, IR_ADD, expT3(16'h0001), "op03_t3");
    applyStimulus(1'b0, 1'b0, 1'b1, IR_ADD, expIdle(), "op03_reset");
    fetch(IR_OPB, "op0b");
    applyStimulus(1'b1, 1'b1, 1'b1, IR_OPB, expT3(16'h0001), "op0b_t3");
    applyStimulus(1'b0, 1'b0, 1'b1, IR_OPB, expIdle(), "op0b_reset");
    fetch(IR_OP2, "op02");
    applyStimulus(1'b1, 1'b1, 1'b1, IR_OP2, expHalt(1'b1), "op02_illegal");
    applyStimulus(1'b0, 1'b0, 1'b1, IR_OP2, expIdle(), "op02_reset");
    fetch(IR_OPC, "op0c");
    applyStimulus(1'b1, 1'b1, 1'b1, IR_OPC, expHalt(1'b1), "op0c_illegal");
    applyStimulus(1'b0, 1'b0, 1'b1, IR_OPC, expIdle(), "op0c_reset");

    // Multiply: LO to Ra=2, HI to Ra+1 when built in; illegal otherwise.
    fetch(IR_MUL, "mul");
`ifdef ALU_SEQUENCER_MULDIV_EN
    applyStimulus(1'b1, 1'b1, 1'b1, IR_MUL, expT3(16'h0008), "mul_t3");
    applyStimulus(1'b1, 1'b1, 1'b1, IR_MUL, expT4(16'h0010, 5'b01111), "mul_t4");
    applyStimulus(1'b1, 1'b1, 1'b1, IR_MUL, expT5(16'h0004), "mul_t5");
    applyStimulus(1'b1, 1'b0, 1'b1, IR_MUL, expT6(16'h0008), "mul_t6");
    applyStimulus(1'b1, 1'b0, 1'b1, IR_MUL, expIdle(), "mul_idle");
`else
    applyStimulus(1'b1, 1'b1, 1'b1, IR_MUL, expHalt(1'b1), "mul_illegal");
    applyStimulus(1'b0, 1'b0, 1'b1, IR_MUL, expIdle(), "mul_reset");
`endif

    repeat (2) @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
